// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a one-entry holding register.
// Recovers LSB-first frames at CLKS_PER_BIT clocks per bit, presents each good byte
// through a valid/ack handshake, and pulses frame_err / overrun on bad or dropped frames.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rd_ack,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned Half = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  // Last count of a full bit period.
  localparam logic [CntW-1:0] CntBitEnd = CntW'(CLKS_PER_BIT - 1);
  // START is entered on the detection edge, so the mid-start sample falls HALF edges
  // later, i.e. when the counter still reads HALF-1.
  localparam logic [CntW-1:0] CntHalf   = CntW'(Half - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // Synchronizer
  logic       sync1_q, sync1_d;
  logic       rx_s_q, rx_s_d;
  // Tracks whether rx_s_q holds a real line sample rather than its reset value.
  logic [1:0] sync_vld_q, sync_vld_d;

  // Receiver state
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              armed_q, armed_d;

  // Holding register and flags
  logic [7:0]        p_data_q, p_data_d;
  logic              dv_q, dv_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;

  // Next-state for the two-flop synchronizer and its fill tracker.
  always_comb begin
    sync1_d    = rx_in;
    rx_s_d     = sync1_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
  end

  // Synchronizer flops; reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      sync_vld_q <= 2'b00;
    end else begin
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      sync_vld_q <= sync_vld_d;
    end
  end

  // Frame FSM next-state, shift register, holding register and flag pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    armed_d  = armed_q;
    p_data_d = p_data_q;
    dv_d     = dv_q;
    fe_d     = 1'b0;
    ov_d     = 1'b0;

    // Consumer pop; a load in STOP below overrides this.
    if (dv_q && rd_ack) begin
      dv_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // Only arm on a genuine high sample so a line low out of reset cannot start a frame.
        if (sync_vld_q[1] && rx_s_q) begin
          armed_d = 1'b1;
        end
        if (armed_q && !rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end

      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntHalf) begin
          if (!rx_s_q) begin
            state_d = StData;
            cnt_d   = '0;
            idx_d   = 3'd0;
          end else begin
            // Glitch: line returned high before mid-start.
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
      end

      StData: begin
        if (cnt_q == CntBitEnd) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StStop: begin
        if (cnt_q == CntBitEnd) begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          state_d = StIdle;
          cnt_d   = '0;
          if (rx_s_q) begin
            if (!dv_q || rd_ack) begin
              p_data_d = shift_q;
              dv_d     = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            // Bad stop bit; require the line to go high again before the next start.
            fe_d    = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame FSM and holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'h00;
      armed_q  <= 1'b0;
      p_data_q <= 8'h00;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      armed_q  <= armed_d;
      p_data_q <= p_data_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  // Outputs come straight from registers; busy is a decode of the state register.
  always_comb begin
    p_data     = p_data_q;
    data_valid = dv_q;
    frame_err  = fe_q;
    overrun    = ov_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLKS_PER_BIT=8 (HALF=3).
module tb_uart_rx_core;

  localparam int unsigned Cpb = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in;
  logic       rd_ack;
  logic [7:0] p_data;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Event log filled by the monitor
  int         n_rise = 0, n_fe = 0, n_ov = 0, n_busy = 0;
  int         rise_cyc = 0, prev_rise_cyc = 0;
  int         busy_rise_cyc = 0, busy_fall_cyc = 0, fe_cyc = 0, ov_cyc = 0;
  logic [7:0] rise_bytes[$];
  logic       dv_prev = 1'b0, busy_prev = 1'b0;

  int b_rise, b_fe, b_ov, b_busy;
  int e0, e0a, e0b;

  uart_rx_core #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rd_ack     (rd_ack),
    .p_data     (p_data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record output events on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (data_valid && !dv_prev) begin
        n_rise++;
        prev_rise_cyc = rise_cyc;
        rise_cyc      = cyc;
        rise_bytes.push_back(p_data);
      end
      if (busy && !busy_prev) begin
        n_busy++;
        busy_rise_cyc = cyc;
      end
      if (!busy && busy_prev) busy_fall_cyc = cyc;
      if (frame_err) begin
        n_fe++;
        fe_cyc = cyc;
      end
      if (overrun) begin
        n_ov++;
        ov_cyc = cyc;
      end
    end
    dv_prev   = data_valid;
    busy_prev = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; e0_o is the first rising edge that sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int e0_o);
    e0_o  = cyc + 1;
    rx_in = 1'b0;
    repeat (Cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (Cpb) tick();
    end
    rx_in = stop;
    repeat (Cpb) tick();
  endtask

  // Wait (bounded) for data_valid, then pop it with a one-cycle rd_ack.
  task automatic pop_when_valid();
    int n = 0;
    while (data_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("pop_wait", data_valid, 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  task automatic snap();
    b_rise = n_rise;
    b_fe   = n_fe;
    b_ov   = n_ov;
    b_busy = n_busy;
  endtask

  initial begin
    rx_in  = 1'b1;
    rd_ack = 1'b0;
    #1 rst = 1'b0;
    repeat (3) tick();

    // Reset values
    check("rst_pdata", p_data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    repeat (10) tick();

    // Single byte 0xA5, left unread then popped
    snap();
    send_frame(8'hA5, 1'b1, e0);
    repeat (4) tick();
    check("t1_rise_n", n_rise - b_rise, 1);
    check("t1_rise_cyc", rise_cyc, e0 + 77);
    check("t1_pdata", p_data, 8'hA5);
    check("t1_busy_rise", busy_rise_cyc, e0 + 2);
    check("t1_busy_fall", busy_fall_cyc, e0 + 77);
    check("t1_no_err", (n_fe - b_fe) + (n_ov - b_ov), 0);
    check("t1_dv_hold", data_valid, 1);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t1_dv_pop", data_valid, 0);
    check("t1_pdata_keep", p_data, 8'hA5);

    // Back-to-back 0x00 then 0xFF, zero idle gap
    repeat (5) tick();
    snap();
    fork
      begin
        send_frame(8'h00, 1'b1, e0a);
        send_frame(8'hFF, 1'b1, e0b);
      end
      begin
        pop_when_valid();
        pop_when_valid();
      end
    join
    repeat (4) tick();
    check("t2_rise_n", n_rise - b_rise, 2);
    check("t2_byte0", rise_bytes[b_rise], 8'h00);
    check("t2_byte1", rise_bytes[b_rise + 1], 8'hFF);
    check("t2_gap", rise_cyc - prev_rise_cyc, 80);
    check("t2_rise_cyc", rise_cyc, e0b + 77);
    check("t2_no_err", (n_fe - b_fe) + (n_ov - b_ov), 0);
    check("t2_dv", data_valid, 0);

    // False start: 2-cycle glitch
    repeat (5) tick();
    snap();
    rx_in = 1'b0;
    repeat (2) tick();
    rx_in = 1'b1;
    repeat (20) tick();
    check("t3_busy_pulse", n_busy - b_busy, 1);
    check("t3_busy_idle", busy, 0);
    check("t3_no_rise", n_rise - b_rise, 0);
    check("t3_no_err", (n_fe - b_fe) + (n_ov - b_ov), 0);
    fork
      send_frame(8'h3C, 1'b1, e0);
      pop_when_valid();
    join
    repeat (4) tick();
    check("t3_byte", rise_bytes[$], 8'h3C);
    check("t3_rise_cyc", rise_cyc, e0 + 77);

    // Framing error on 0x5A, then line held low as a break
    repeat (5) tick();
    snap();
    send_frame(8'h5A, 1'b0, e0);
    repeat (30) tick();
    check("t4_fe_n", n_fe - b_fe, 1);
    check("t4_fe_cyc", fe_cyc, e0 + 77);
    check("t4_no_rise", n_rise - b_rise, 0);
    check("t4_dv", data_valid, 0);
    check("t4_no_restart", n_busy - b_busy, 1);
    check("t4_busy", busy, 0);
    rx_in = 1'b1;
    repeat (10) tick();
    fork
      send_frame(8'h11, 1'b1, e0);
      pop_when_valid();
    join
    repeat (4) tick();
    check("t4_byte", rise_bytes[$], 8'h11);
    check("t4_fe_once", n_fe - b_fe, 1);

    // Overrun: 0x12 unread, then 0x34 arrives
    repeat (5) tick();
    snap();
    send_frame(8'h12, 1'b1, e0a);
    repeat (4) tick();
    send_frame(8'h34, 1'b1, e0b);
    repeat (4) tick();
    check("t5_ov_n", n_ov - b_ov, 1);
    check("t5_ov_cyc", ov_cyc, e0b + 77);
    check("t5_pdata_old", p_data, 8'h12);
    check("t5_dv", data_valid, 1);
    check("t5_rise_n", n_rise - b_rise, 1);
    check("t5_no_fe", n_fe - b_fe, 0);

    // Same again, but rd_ack on the stop-sample cycle: the load wins
    snap();
    fork
      send_frame(8'h34, 1'b1, e0);
      begin
        repeat (77) tick();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
      end
    join
    repeat (4) tick();
    check("t5b_pdata", p_data, 8'h34);
    check("t5b_dv", data_valid, 1);
    check("t5b_no_ov", n_ov - b_ov, 0);
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("t5b_dv_pop", data_valid, 0);

    // Reset during data bit 4 of 0xE7, line low at release
    repeat (5) tick();
    snap();
    rx_in = 1'b0;
    repeat (Cpb) tick();
    for (int i = 0; i < 4; i++) begin
      rx_in = (i < 3) ? 1'b1 : 1'b0;
      repeat (Cpb) tick();
    end
    rx_in = 1'b0;
    repeat (3) tick();
    check("t6_busy_mid", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    repeat (3) tick();
    check("t6_pdata", p_data, 8'h00);
    check("t6_dv", data_valid, 0);
    check("t6_fe", frame_err, 0);
    check("t6_ov", overrun, 0);
    rst = 1'b1;
    b_busy = n_busy;
    repeat (20) tick();
    check("t6_no_start", n_busy - b_busy, 0);
    check("t6_busy_low", busy, 0);
    rx_in = 1'b1;
    repeat (10) tick();
    fork
      send_frame(8'hC3, 1'b1, e0);
      pop_when_valid();
    join
    repeat (4) tick();
    check("t6_byte", rise_bytes[$], 8'hC3);
    check("t6_rise_cyc", rise_cyc, e0 + 77);
    check("t6_no_err", (n_fe - b_fe) + (n_ov - b_ov), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
